// File: rtl/vram_arb_pkg.sv
// Shared types for the video-BRAM port arbiter: requester IDs and the
// read-return owner record carried alongside each BRAM access.
package vram_arb_pkg;

   localparam int DEF_DW = 32;
   localparam int DEF_AW = 15;

   typedef enum logic [1:0] {
      RID_NONE,
      RID_VID,
      RID_CPU,
      RID_DMA
   } req_id_t;

   typedef struct packed {
      req_id_t id;
      logic    rd;
   } owner_t;

   localparam owner_t OWNER_IDLE = '{id: RID_NONE, rd: 1'b0};

endpackage

// File: rtl/vram_arb_rr.sv
// Two-way round-robin arbiter: on a tie the pointer picks the requester
// that was not served last; the pointer moves only when a grant is issued.
module vram_arb_rr (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_req,
   input  logic       i_enable,
   output logic [1:0] o_grant
);

   logic       r_ptr;
   logic [1:0] w_grant;

   always_comb begin
      w_grant = 2'b00;
      if (i_enable) begin
         if (i_req == 2'b11) begin
            w_grant = r_ptr ? 2'b10 : 2'b01;
         end else begin
            w_grant = i_req;
         end
      end
   end

   // After serving index 0, favour index 1 next time, and vice versa.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= 1'b0;
      end else if (|w_grant) begin
         r_ptr <= w_grant[0];
      end
   end

   assign o_grant = w_grant;

endmodule

// File: rtl/vram_port_arbiter.sv
// Shares BRAM port B between video scan-out (priority, run-limited), CPU and
// DMA (round-robin). Accesses are registered; reads return tagged two cycles later.
module vram_port_arbiter
   import vram_arb_pkg::*;
#(
   parameter int DW          = DEF_DW,
   parameter int AW          = DEF_AW,
   parameter int MAX_VID_RUN = 8
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_ack,
   output logic          vid_rvalid,
   output logic [DW-1:0] vid_rdata,
   input  logic          cpu_req,
   input  logic [3:0]    cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          dma_req,
   input  logic [3:0]    dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_ack,
   output logic          dma_rvalid,
   output logic [DW-1:0] dma_rdata,
   output logic [3:0]    ram_wren,
   output logic [AW-1:0] ram_address,
   output logic [DW-1:0] ram_data,
   input  logic [DW-1:0] ram_q
);

   logic [7:0]    r_vid_run;
   logic [3:0]    r_ram_wren;
   logic [AW-1:0] r_ram_address;
   logic [DW-1:0] r_ram_data;
   owner_t        r_own1;
   owner_t        r_own2;

   logic          w_other_req;
   logic          w_vid_mask;
   logic          w_vid_grant;
   logic [1:0]    w_rr_grant;
   logic          w_any_grant;
   logic [3:0]    w_sel_wren;
   logic [AW-1:0] w_sel_addr;
   logic [DW-1:0] w_sel_data;
   owner_t        w_sel_own;

   assign w_other_req = cpu_req | dma_req;
   assign w_vid_mask  = (r_vid_run == 8'(MAX_VID_RUN));
   assign w_vid_grant = vid_req & ~w_vid_mask;

   vram_arb_rr u_rr (
      .clk      (clock),
      .rst_n    (reset_n),
      .i_req    ({dma_req, cpu_req}),
      .i_enable (~w_vid_grant),
      .o_grant  (w_rr_grant)
   );

   // Acks are held low while reset is asserted even if a requester is waiting.
   assign vid_ack = w_vid_grant   & reset_n;
   assign cpu_ack = w_rr_grant[0] & reset_n;
   assign dma_ack = w_rr_grant[1] & reset_n;

   always_comb begin
      w_any_grant = 1'b1;
      w_sel_wren  = 4'b0000;
      w_sel_addr  = r_ram_address;
      w_sel_data  = r_ram_data;
      w_sel_own   = OWNER_IDLE;
      if (w_vid_grant) begin
         w_sel_addr = vid_addr;
         w_sel_own  = '{id: RID_VID, rd: 1'b1};
      end else if (w_rr_grant[0]) begin
         w_sel_wren = cpu_we;
         w_sel_addr = cpu_addr;
         w_sel_data = cpu_wdata;
         w_sel_own  = '{id: RID_CPU, rd: (cpu_we == 4'b0000)};
      end else if (w_rr_grant[1]) begin
         w_sel_wren = dma_we;
         w_sel_addr = dma_addr;
         w_sel_data = dma_wdata;
         w_sel_own  = '{id: RID_DMA, rd: (dma_we == 4'b0000)};
      end else begin
         w_any_grant = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_vid_run     <= 8'd0;
         r_ram_wren    <= 4'b0000;
         r_ram_address <= '0;
         r_ram_data    <= '0;
         r_own1        <= OWNER_IDLE;
         r_own2        <= OWNER_IDLE;
      end else begin
         r_ram_wren <= w_sel_wren;
         if (w_any_grant) begin
            r_ram_address <= w_sel_addr;
            r_ram_data    <= w_sel_data;
         end
         r_own1 <= w_sel_own;
         r_own2 <= r_own1;
         // The run only counts video grants that actually delay CPU/DMA.
         if ((|w_rr_grant) || !w_other_req) begin
            r_vid_run <= 8'd0;
         end else if (w_vid_grant) begin
            r_vid_run <= r_vid_run + 8'd1;
         end
      end
   end

   assign ram_wren    = r_ram_wren;
   assign ram_address = r_ram_address;
   assign ram_data    = r_ram_data;

   assign vid_rvalid = r_own2.rd && (r_own2.id == RID_VID);
   assign cpu_rvalid = r_own2.rd && (r_own2.id == RID_CPU);
   assign dma_rvalid = r_own2.rd && (r_own2.id == RID_DMA);
   assign vid_rdata  = ram_q;
   assign cpu_rdata  = ram_q;
   assign dma_rdata  = ram_q;

endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares one port of the dual-port video BRAM between three requesters: video scan-out fetch (read-only), CPU, and DMA/blitter.
- Video has fixed priority, bounded by a starvation limit. CPU and DMA are served round-robin.
- All BRAM-side signals are registered. Read data returns tagged per requester with fixed latency.
- Sits between the bus/scan-out logic and the BRAM port B; port A stays with the host side.

Parameters:
- DW, 32, data width of the BRAM port and of every requester data bus.
- AW, 15, word address width.
- MAX_VID_RUN, 8, consecutive video grants allowed while CPU or DMA is pending; range 1..255.

Ports:
- clock  in  1  single clock for the block and the BRAM port.
- reset_n  in  1  asynchronous active-low reset.
- vid_req  in  1  video read request.
- vid_addr  in  AW  video word address.
- vid_ack  out  1  video request accepted this cycle (combinational).
- vid_rvalid  out  1  video read data valid.
- vid_rdata  out  DW  video read data.
- cpu_req  in  1  CPU request.
- cpu_we  in  4  CPU byte write enables; 0 means read.
- cpu_addr  in  AW  CPU word address.
- cpu_wdata  in  DW  CPU write data.
- cpu_ack  out  1  CPU request accepted (combinational).
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DW  CPU read data.
- dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rvalid, dma_rdata: same widths and meaning as the cpu_* ports.
- ram_wren  out  4  to BRAM wren.
- ram_address  out  AW  to BRAM address.
- ram_data  out  DW  to BRAM data.
- ram_q  in  DW  from BRAM q; 1-cycle registered read.

Behaviour:
- Handshake:
  - req/ack follows valid/ready. The requester holds req and its fields stable until it samples ack=1 on a rising edge.
  - The requester may present the next request in the following cycle, giving 1 access/cycle peak.
  - ack is never asserted without the matching req in the same cycle.
  - At most one ack is asserted per cycle.
- Arbitration, cycle N:
  - If vid_req and the video run is not exhausted: grant video.
  - Otherwise grant the round-robin winner among cpu_req and dma_req.
  - The round-robin pointer favours the requester not served last. It updates only on a CPU or DMA grant.
  - Reset value of the pointer: CPU first.
- Starvation counter vid_run (8 bit):
  - Increments on each video grant while cpu_req or dma_req is high.
  - Clears on any CPU or DMA grant, and on any cycle in which neither cpu_req nor dma_req is high.
  - When vid_run == MAX_VID_RUN, video is masked for one cycle.
  - If video is masked and nothing else is requesting, which cannot occur by construction, no grant is issued.
- BRAM issue: the grant in cycle N registers ram_address/ram_wren/ram_data, visible in N+1.
  - Video grants drive wren=0.
  - Without a grant: ram_wren=0, and ram_address/ram_data hold their previous values.
- Read return: ram_q is valid in N+2.
  - A 2-stage owner pipeline (ID + is_read) drives the selected xxx_rvalid high for exactly one cycle in N+2.
  - xxx_rdata = ram_q, combinational pass-through, for all three requesters; it is meaningful only when the matching rvalid is high.
- Writes: any nonzero we produces no rvalid. The BRAM write-through q value is ignored.
- Ordering: per requester, reads return in issue order. A read issued after a write to the same address by any requester returns the new data, because the BRAM port is serialised.
- Reset (async assert, sync deassert by upstream):
  - All acks 0, all rvalid 0, ram_wren 0, ram_address 0, ram_data 0.
  - vid_run 0, round-robin pointer = CPU, owner pipeline cleared.
  - Reads in flight at reset are dropped; no rvalid is produced for them.
- Simultaneous events:
  - All three requesting: video wins unless its run is exhausted.
  - CPU and DMA requesting with video masked: the round-robin winner is granted.

Decomposition:
- Shared package vram_arb_pkg:
  - enum req_id_t {RID_NONE, RID_VID, RID_CPU, RID_DMA}.
  - Owner-pipeline struct {req_id_t id; logic rd;}.
  - Default AW/DW constants.
- Sub-module vram_arb_rr: 2-way round-robin arbiter with pointer, inputs req[1:0]/enable, outputs one-hot grant. Reused by other shared-memory arbiters.
- Top contains the priority/starvation logic, issue registers and return pipeline.

Test Plan:
- CPU read, addr 0x0010, BRAM preloaded 0xDEADBEEF -> cpu_ack in cycle N, ram_address=0x0010 with wren=0 in N+1, cpu_rvalid=1 with cpu_rdata=0xDEADBEEF in N+2 only.
- CPU write we=4'b0011 data 0x12345678 to 0x20, then CPU read 0x20 (prior content 0xAAAAAAAA) -> no rvalid for the write; the read returns 0xAAAA5678.
- vid_req held continuously, cpu_req held, MAX_VID_RUN=8 -> 8 vid_acks, then 1 cpu_ack, then video resumes; the pattern repeats.
- cpu_req and dma_req both held, no video -> acks alternate CPU, DMA, CPU, DMA starting with CPU after reset; per-requester rvalid order matches.
- Back-to-back video reads 0x100..0x103 every cycle -> vid_rvalid high 4 consecutive cycles with data in address order.
- Assert reset_n=0 one cycle after a DMA read ack -> dma_rvalid never asserts; all outputs 0 immediately; after release the first CPU request is granted normally.
